fetch_queue: RTL and testbench

Instruction-fetch front end between the instruction memory and the decode/register-fetch stage of the 16-bit pipelined core. Owns the fetch PC and issues sequential requests to the one-cycle-latency instruction memory. Buffers returned instructions with their PCs in a small FIFO, so decode stalls (branch pending, divide stall) no longer freeze the PC register. A taken-branch redirect flushes the queue and discards any in-flight fetch.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch_queue.sv | 63 ++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types and reset defaults for the 16-bit core.
package cpu_pkg;
   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
   localparam int PC_STEP_DEFAULT = 4;
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch entries; clear beats push and pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_entry_t  data,
   input  logic          pop,
   input  logic          clear,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
      head = (count != '0) ? mem[rd_ptr] : '0;
   end
   // storage needs no reset: pointers and count alone define validity
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= data;
   always_ff @(posedge clk)
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues credit-checked sequential fetches and
// buffers returned instructions with their PCs; redirect flushes everything.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int PC_STEP = PC_STEP_DEFAULT,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   output logic [15:0]   imem_addr,
   output logic          imem_req,
   input  logic [15:0]   imem_instr,
   output logic          dec_valid,
   output logic [15:0]   dec_instr,
   output logic [15:0]   dec_pc,
   input  logic          dec_ready,
   input  logic          redirect,
   input  logic [15:0]   redirect_pc,
   output logic [CW-1:0] count
);
   logic [15:0] fetch_pc, inflight_pc;
   logic inflight, push, pop;
   fetch_entry_t entry, head;
   assign imem_addr = fetch_pc;
   // credit ignores same-cycle pops, so the in-flight return always has a slot
   always_comb begin
      dec_valid = count != '0;
      dec_instr = head.instr;
      dec_pc = head.pc;
      imem_req = !reset && !redirect && (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
      push = inflight && !redirect;
      pop = dec_valid && dec_ready && !redirect;
      entry = '{pc: inflight_pc, instr: imem_instr};
   end
   always_ff @(posedge clk)
      if (reset) begin
         fetch_pc <= RESET_PC;
         inflight <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc <= fetch_pc + 16'(PC_STEP);
            inflight_pc <= fetch_pc;
         end
      end
   fetch_fifo #(.DEPTH(DEPTH)) fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .data(entry),
      .pop(pop),
      .clear(redirect),
      .head(head),
      .count(count)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected PCs popped by a handshake monitor.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;
   logic clk = 1'b0, reset = 1'b1, dec_ready = 1'b1, redirect = 1'b0, prev_req = 1'b0;
   logic [15:0] redirect_pc = '0, imem_instr = '0, imem_addr, dec_instr, dec_pc;
   logic imem_req, dec_valid;
   logic [CW-1:0] count;
   int vectors = 0, errors = 0, hs = 0, h0 = 0;
   logic [15:0] exp_q [$];
   always #5 clk = ~clk;
   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(4)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_instr(imem_instr), .dec_valid(dec_valid), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .dec_ready(dec_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .count(count)
   );
   // one-cycle instruction memory: instruction word is the address divided by 4
   always @(posedge clk) begin
      imem_instr <= imem_req ? imem_addr >> 2 : 16'hDEAD;
      prev_req <= imem_req;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic load(input logic [15:0] start);
      exp_q.delete();
      for (int k = 0; k < 64; k++) exp_q.push_back(start + 16'(4 * k));
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // stop in the cycle after which the FIFO holds 3 entries with a fetch in flight
   task automatic wait_fill();
      int n = 0;
      @(negedge clk);
      while (!(count == 2 && imem_req && prev_req) && n < 30) begin
         step();
         @(negedge clk);
         n++;
      end
      chk("fill_reached", 32'(n < 30), 32'd1);
   endtask
   always @(negedge clk)
      if (!reset && !redirect && dec_valid && dec_ready) begin
         logic [15:0] e;
         hs++;
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_pop: got pc %0h, expected no pop", dec_pc);
         end else begin
            e = exp_q.pop_front();
            chk("pop_pc", 32'(dec_pc), 32'(e));
            chk("pop_instr", 32'(dec_instr), 32'(e >> 2));
         end
      end
   initial begin
      step();
      step();
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(dec_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_pc", 32'(dec_pc), 0);
      chk("rst_instr", 32'(dec_instr), 0);
      step();
      reset = 1'b0;
      load(16'h0000);
      @(negedge clk);
      chk("first_req", 32'(imem_req), 1);
      chk("first_addr", 32'(imem_addr), 0);
      chk("c0_valid", 32'(dec_valid), 0);
      step();
      @(negedge clk);
      chk("c1_valid", 32'(dec_valid), 0);
      step();
      @(negedge clk);
      chk("c2_valid", 32'(dec_valid), 1);
      chk("c2_pc", 32'(dec_pc), 0);
      step();
      h0 = hs;
      repeat (9) step();
      chk("throughput", 32'(hs - h0), 9);
      dec_ready = 1'b0;
      repeat (10) step();
      @(negedge clk);
      chk("stall_count", 32'(count), DEPTH);
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_head", 32'(dec_pc), 32'h28);
      step();
      dec_ready = 1'b1;
      h0 = hs;
      repeat (6) step();
      chk("drain_no_gap", 32'(hs - h0), 6);
      dec_ready = 1'b0;
      wait_fill();
      step();
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      load(16'h0100);
      @(negedge clk);
      chk("redir_pre_count", 32'(count), 3);
      chk("redir_req", 32'(imem_req), 0);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("redir_t1_count", 32'(count), 0);
      chk("redir_t1_valid", 32'(dec_valid), 0);
      chk("redir_t1_addr", 32'(imem_addr), 32'h0100);
      step();
      @(negedge clk);
      chk("redir_t2_count", 32'(count), 0);
      step();
      @(negedge clk);
      chk("redir_t3_valid", 32'(dec_valid), 1);
      chk("redir_t3_pc", 32'(dec_pc), 32'h0100);
      chk("redir_t3_instr", 32'(dec_instr), 32'h0040);
      step();
      dec_ready = 1'b1;
      repeat (8) step();
      redirect = 1'b1;
      redirect_pc = 16'hFFF8;
      load(16'hFFF8);
      step();
      redirect = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("wrap_t3_pc", 32'(dec_pc), 32'hFFF8);
      step();
      h0 = hs;
      repeat (3) step();
      chk("wrap_seq", 32'(hs - h0), 3);
      reset = 1'b1;
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      @(negedge clk);
      chk("rr_req", 32'(imem_req), 0);
      step();
      reset = 1'b0;
      redirect = 1'b0;
      load(16'h0000);
      @(negedge clk);
      chk("rr_count", 32'(count), 0);
      chk("rr_valid", 32'(dec_valid), 0);
      chk("rr_addr", 32'(imem_addr), 0);
      chk("rr_req_after", 32'(imem_req), 1);
      step();
      step();
      @(negedge clk);
      chk("rr_t3_pc", 32'(dec_pc), 0);
      step();
      dec_ready = 1'b0;
      wait_fill();
      step();
      dec_ready = 1'b1;
      @(negedge clk);
      chk("pp_pre_count", 32'(count), DEPTH - 1);
      step();
      dec_ready = 1'b0;
      @(negedge clk);
      chk("pp_count", 32'(count), DEPTH - 1);
      step();
      redirect = 1'b1;
      redirect_pc = 16'h0300;
      dec_ready = 1'b1;
      load(16'h0300);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("empty_t1_count", 32'(count), 0);
      step();
      @(negedge clk);
      chk("empty_pop_count", 32'(count), 0);
      step();
      @(negedge clk);
      chk("empty_t3_pc", 32'(dec_pc), 32'h0300);
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
